// File: rtl/sat_eval_sequencer_pkg.sv
// Shared definitions for the SAT evaluation sequencer: synchronizer stateVal codes,
// FSM state encoding and index-width helper.
// Pure declarations: no latency, no flow control.
package sat_eval_sequencer_pkg;

    // Codes driven onto the synchronizer stateVal input.
    localparam logic [1:0] SAT_RESET  = 2'b00;
    localparam logic [1:0] SAT_CLAUSE = 2'b01;
    localparam logic [1:0] SAT_CNF    = 2'b10;
    localparam logic [1:0] SAT_CLR    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_LIT    = 3'd2,
        ST_CNF    = 3'd3,
        ST_CLR    = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_FINISH = 3'd6
    } sat_state_t;

    // Index width for a loop of n iterations; never narrower than one bit.
    function automatic int sat_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_eval_sequencer_if.sv
// Job/status bundle between host, sequencer and clause datapath.
// Wires only: no latency; start is a single-cycle request, no ready (ignored while busy).
// Ports: start/num_clauses/lits_per_clause/cnf_val toward the sequencer,
//        state_val/clause_idx/lit_idx/busy/done/sat from the sequencer.
interface sat_eval_sequencer_if
    import sat_eval_sequencer_pkg::*;
#(
    parameter int MAX_CLAUSES = 64,
    parameter int MAX_LITS    = 8
);
    localparam int CW = sat_idx_w(MAX_CLAUSES);
    localparam int LW = sat_idx_w(MAX_LITS);

    logic          start;
    logic [CW:0]   num_clauses;
    logic [LW:0]   lits_per_clause;
    logic          cnf_val;
    logic [1:0]    state_val;
    logic [CW-1:0] clause_idx;
    logic [LW-1:0] lit_idx;
    logic          busy;
    logic          done;
    logic          sat;

    // Host / datapath side.
    modport master (
        output start, num_clauses, lits_per_clause, cnf_val,
        input  state_val, clause_idx, lit_idx, busy, done, sat
    );

    // Sequencer side.
    modport slave (
        input  start, num_clauses, lits_per_clause, cnf_val,
        output state_val, clause_idx, lit_idx, busy, done, sat
    );
endinterface

// File: rtl/sat_eval_sequencer_loop_counter.sv
// Loop index counter with synchronous load, count enable and terminal-count flag.
// Latency: count updates on the edge after i_load/i_en; o_tc is combinational from the count.
// Backpressure: none; the owner stalls the loop by dropping i_en.
// Ports: clk, rst (async high), i_load/i_load_val, i_en, i_last (terminal value), o_cnt, o_tc.
module sat_loop_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_last);
endmodule

// File: rtl/sat_eval_sequencer.sv
// Sequencer for one SAT CNF pass: drives stateVal, walks clause/literal indices, reports sat.
// Latency: done 1 + N*(L+1) + (N-1) + DRAIN_CYC + 1 cycles after the accepted start edge.
// Backpressure: start is accepted only in IDLE; requests while busy or in FINISH are dropped.
// Ports: clk, reset (async high), bus (slave modport of sat_eval_sequencer_if).
// Option: define SAT_EARLY_EXIT_EN to abort to FINISH with sat=0 as soon as the CNF
//         register reads 0 during a literal cycle of any clause after clause 0.
module sat_eval_sequencer
    import sat_eval_sequencer_pkg::*;
#(
    parameter int MAX_CLAUSES = 64,
    parameter int MAX_LITS    = 8,
    parameter int DRAIN_CYC   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sat_eval_sequencer_if.slave  bus
);
    localparam int CW = sat_idx_w(MAX_CLAUSES);
    localparam int LW = sat_idx_w(MAX_LITS);
    localparam int DW = sat_idx_w(DRAIN_CYC + 1);

    localparam logic [CW:0]   MAXC       = (CW+1)'(MAX_CLAUSES);
    localparam logic [LW:0]   MAXL       = (LW+1)'(MAX_LITS);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    sat_state_t    r_state, w_next;

    // Per-pass configuration captured at the accepted start.
    logic          r_n_zero;
    logic [CW-1:0] r_clause_last;
    logic [LW-1:0] r_lit_last;

    logic [DW-1:0] r_drn_cnt;
    logic          r_sat;
    // Passes that end without a DRAIN (N==0, early abort) carry a fixed result
    // instead of the live CNF register value.
    logic          r_fin_force;
    logic          r_fin_val;

    logic [CW:0]   w_n_sat;
    logic [LW:0]   w_l_sat;
    logic [CW-1:0] w_clause_idx;
    logic [LW-1:0] w_lit_idx;
    logic          w_cl_tc, w_lit_tc;
    logic          w_accept;
    logic          w_lit_load, w_lit_en, w_cl_load, w_cl_en;
    logic          w_drn_clr, w_drn_en;
    logic          w_force_set, w_force_val;
    logic          w_fin_result;

    // Out-of-range requests clamp to the hardware maximum; a zero literal count
    // still needs one literal cycle so the clause gets evaluated.
    assign w_n_sat = (bus.num_clauses > MAXC) ? MAXC : bus.num_clauses;
    assign w_l_sat = (bus.lits_per_clause > MAXL)  ? MAXL :
                     (bus.lits_per_clause == '0)   ? (LW+1)'(1) : bus.lits_per_clause;

    sat_loop_counter #(.W(LW)) u_lit_cnt (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_lit_load),
        .i_load_val ('0),
        .i_en       (w_lit_en),
        .i_last     (r_lit_last),
        .o_cnt      (w_lit_idx),
        .o_tc       (w_lit_tc)
    );

    sat_loop_counter #(.W(CW)) u_clause_cnt (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_cl_load),
        .i_load_val ('0),
        .i_en       (w_cl_en),
        .i_last     (r_clause_last),
        .o_cnt      (w_clause_idx),
        .o_tc       (w_cl_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_lit_load  = 1'b0;
        w_lit_en    = 1'b0;
        w_cl_load   = 1'b0;
        w_cl_en     = 1'b0;
        w_drn_clr   = 1'b0;
        w_drn_en    = 1'b0;
        w_force_set = 1'b0;
        w_force_val = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept   = 1'b1;
                    w_lit_load = 1'b1;
                    w_cl_load  = 1'b1;
                    w_next     = ST_INIT;
                end
            end
            ST_INIT: begin
                if (r_n_zero) begin
                    // Empty CNF is trivially satisfied.
                    w_next      = ST_FINISH;
                    w_force_set = 1'b1;
                    w_force_val = 1'b1;
                end else begin
                    w_next = ST_LIT;
                end
            end
            ST_LIT: begin
                if (w_lit_tc) begin
                    w_next = ST_CNF;
                end else begin
                    w_lit_en = 1'b1;
                end
`ifdef SAT_EARLY_EXIT_EN
                // Once a completed clause has zeroed the CNF register it cannot
                // recover; indices freeze where the abort happened.
                if ((w_clause_idx != '0) && !bus.cnf_val) begin
                    w_next      = ST_FINISH;
                    w_lit_en    = 1'b0;
                    w_force_set = 1'b1;
                    w_force_val = 1'b0;
                end
`endif
            end
            ST_CNF: begin
                w_drn_clr = 1'b1;
                if (w_cl_tc) begin
                    w_next = (DRAIN_CYC == 0) ? ST_FINISH : ST_DRAIN;
                end else begin
                    w_next = ST_CLR;
                end
            end
            ST_CLR: begin
                w_cl_en    = 1'b1;
                w_lit_load = 1'b1;
                w_next     = ST_LIT;
            end
            ST_DRAIN: begin
                // Stays on the CNF code so the synchronizer and CNF register
                // settle; re-ANDing the last clause does not change the result.
                if (r_drn_cnt == DRAIN_LAST) begin
                    w_next = ST_FINISH;
                end else begin
                    w_drn_en = 1'b1;
                end
            end
            ST_FINISH: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n_zero      <= 1'b0;
            r_clause_last <= '0;
            r_lit_last    <= '0;
        end else if (w_accept) begin
            r_n_zero      <= (w_n_sat == '0);
            r_clause_last <= CW'(w_n_sat - 1'b1);
            r_lit_last    <= LW'(w_l_sat - 1'b1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drn_cnt <= '0;
        end else if (w_drn_clr) begin
            r_drn_cnt <= '0;
        end else if (w_drn_en) begin
            r_drn_cnt <= r_drn_cnt + 1'b1;
        end
    end

    assign w_fin_result = r_fin_force ? r_fin_val : bus.cnf_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat       <= 1'b0;
            r_fin_force <= 1'b0;
            r_fin_val   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sat       <= 1'b0;
                r_fin_force <= 1'b0;
            end
            if (w_force_set) begin
                r_fin_force <= 1'b1;
                r_fin_val   <= w_force_val;
            end
            if (r_state == ST_FINISH) begin
                r_sat <= w_fin_result;
            end
        end
    end

    always_comb begin
        bus.state_val = SAT_RESET;
        unique case (r_state)
            ST_LIT:   bus.state_val = SAT_CLAUSE;
            ST_CNF:   bus.state_val = SAT_CNF;
            ST_DRAIN: bus.state_val = SAT_CNF;
            ST_CLR:   bus.state_val = SAT_CLR;
            default:  bus.state_val = SAT_RESET;
        endcase
    end

    assign bus.clause_idx = w_clause_idx;
    assign bus.lit_idx    = w_lit_idx;
    assign bus.busy       = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign bus.done       = (r_state == ST_FINISH);
    // The result is visible in the done cycle itself and held afterwards.
    assign bus.sat        = (r_state == ST_FINISH) ? w_fin_result : r_sat;
endmodule

// File: tb/tb_sat_eval_sequencer.sv
// Bench for sat_eval_sequencer: randomized and directed passes, reference trace queued
// per cycle, monitor on the opposite clock edge pops and compares.
module tb_sat_eval_sequencer;
    import sat_eval_sequencer_pkg::*;

    localparam int MAXC = 64;
    localparam int MAXL = 8;
    localparam int DRN  = 2;
    localparam int CW   = sat_idx_w(MAXC);
    localparam int LW   = sat_idx_w(MAXL);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sat_eval_sequencer_if #(.MAX_CLAUSES(MAXC), .MAX_LITS(MAXL)) bus ();

    sat_eval_sequencer #(.MAX_CLAUSES(MAXC), .MAX_LITS(MAXL), .DRAIN_CYC(DRN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int       cyc;
        logic [1:0] sv;
        logic     busy;
        logic     done;
        bit       chk_idx;
        int       ci;
        int       li;
        bit       chk_sat;
        logic     sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, exp);
        end
    endtask

    function automatic void push(input int c, input logic [1:0] sv, input logic b, input logic d,
                                 input bit ic, input int ci, input int li,
                                 input bit sc, input logic s);
        exp_t e;
        e.cyc = c; e.sv = sv; e.busy = b; e.done = d;
        e.chk_idx = ic; e.ci = ci; e.li = li; e.chk_sat = sc; e.sat = s;
        exp_q.push_back(e);
    endfunction

    // Reference: lists the pass cycle by cycle from the protocol description.
    // cnf_val in cycle t is (t < drop). Returns the cycle offset of done.
    function automatic int model_pass(input int c0, input int n_in, input int l_in, input int drop);
        int n, l, t;
        n = (n_in > MAXC) ? MAXC : n_in;
        l = (l_in > MAXL) ? MAXL : ((l_in < 1) ? 1 : l_in);
        t = 1;
        push(c0 + t, 2'b00, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        if (n == 0) begin
            t++;
            push(c0 + t, 2'b00, 1'b0, 1'b1, 1, 0, 0, 1, 1'b1);
            return t;
        end
        for (int c = 0; c < n; c++) begin
            for (int j = 0; j < l; j++) begin
                t++;
                push(c0 + t, 2'b01, 1'b1, 1'b0, 1, c, j, 0, 1'b0);
`ifdef SAT_EARLY_EXIT_EN
                if (c > 0 && t >= drop) begin
                    t++;
                    push(c0 + t, 2'b00, 1'b0, 1'b1, 1, c, j, 1, 1'b0);
                    return t;
                end
`endif
            end
            t++;
            push(c0 + t, 2'b10, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
            if (c < n - 1) begin
                t++;
                push(c0 + t, 2'b11, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
            end
        end
        for (int d = 0; d < DRN; d++) begin
            t++;
            push(c0 + t, 2'b10, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        end
        t++;
        push(c0 + t, 2'b00, 1'b0, 1'b1, 1, n - 1, l - 1, 1, (t < drop) ? 1'b1 : 1'b0);
        return t;
    endfunction

    // Literal stateVal sequence for the N=3, L=2 pass.
    function automatic int table_pass(input int c0);
        logic [1:0] tbl [15];
        tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b01, 2'b01, 2'b10,
                2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
        for (int k = 0; k < 15; k++) begin
            push(c0 + k + 1, tbl[k], (k < 14) ? 1'b1 : 1'b0, (k == 14) ? 1'b1 : 1'b0,
                 (k == 14), 2, 1, (k == 14), 1'b1);
        end
        return 15;
    endfunction

    task automatic run_pass(input int n, input int l, input int drop, input bit use_tbl,
                            input int repulse, input bit fin_pulse, input int rst_at);
        int c0, lat;
        @(posedge clk); #2;
        bus.num_clauses     = (CW+1)'(n);
        bus.lits_per_clause = (LW+1)'(l);
        bus.cnf_val         = 1'b1;
        bus.start           = 1'b1;
        c0  = cyc;
        lat = use_tbl ? table_pass(c0) : model_pass(c0, n, l, drop);
        for (int t = 1; t <= lat + 1; t++) begin
            @(posedge clk); #2;
            bus.start   = ((repulse > 0) && (t == repulse) && (t < lat)) || (fin_pulse && (t == lat));
            bus.cnf_val = (t < drop);
            if (bus.start) begin
                bus.num_clauses     = (CW+1)'($urandom_range(0, 127));
                bus.lits_per_clause = (LW+1)'($urandom_range(0, 15));
            end
            if (t == rst_at) begin
                reset = 1'b1;
                exp_q.delete();
                #1;
                chk("reset_outputs",
                    {bus.state_val, bus.busy, bus.done, bus.sat, bus.clause_idx, bus.lit_idx}, 0);
                @(posedge clk); #2;
                reset     = 1'b0;
                bus.start = 1'b0;
                return;
            end
        end
    endtask

    // Monitor: compares every cycle against the queued trace, or against idle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("missed_entry", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("trace_sv_busy_done", {bus.state_val, bus.busy, bus.done}, {e.sv, e.busy, e.done});
            if (e.chk_idx)
                chk("indices", {bus.clause_idx, bus.lit_idx}, (e.ci << LW) | e.li);
            if (e.chk_sat)
                chk("sat", bus.sat, e.sat);
        end else begin
            chk("idle", {bus.state_val, bus.busy, bus.done}, 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, l, drop;
        reset               = 1'b1;
        bus.start           = 1'b0;
        bus.num_clauses     = '0;
        bus.lits_per_clause = '0;
        bus.cnf_val         = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state",
            {bus.state_val, bus.busy, bus.done, bus.sat, bus.clause_idx, bus.lit_idx}, 0);
        reset = 1'b0;

        run_pass(3, 2, 100000, 1, 0, 0, 0);   // stateVal table
        run_pass(0, 3, 100000, 0, 0, 0, 0);   // empty CNF
        run_pass(4, 3, 100000, 0, 0, 0, 0);   // satisfied
        run_pass(4, 3, 6, 0, 0, 0, 0);        // CNF drops to 0
        run_pass(3, 2, 100000, 0, 0, 0, 5);   // reset mid-pass
        run_pass(3, 2, 100000, 1, 0, 0, 0);   // full pass after reset
        run_pass(2, 0, 100000, 0, 3, 1, 0);   // L=0, start while busy and in FINISH
        run_pass(8, 2, 6, 0, 0, 0, 0);        // early-exit scenario
        run_pass(100, 15, 100000, 0, 0, 0, 0); // saturation

        for (int i = 0; i < 25; i++) begin
            n    = ($urandom_range(0, 9) == 0) ? $urandom_range(65, 127) : $urandom_range(0, 10);
            l    = $urandom_range(0, 15);
            drop = ($urandom_range(0, 1) == 0) ? $urandom_range(2, 80) : 100000;
            run_pass(n, l, drop, 0, $urandom_range(0, 6), 1'($urandom_range(0, 1)), 0);
        end

        repeat (5) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
